// File: rtl/game_pkg.sv
// game_pkg: shared game types and geometry for draw_game and game_ctrl.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: game_state_t, bcd_digit_t, screen/bird/tube geometry, score limits,
//   tube_right() helper giving a tube's right edge in 12 bits.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int BIRD_X       = 200;
  localparam int TUBE_WIDTH   = 120;
  localparam int N_TUBES      = 3;
  localparam int SCREEN_W     = 1024;
  localparam int DEATH_FRAMES = 90;
  localparam logic [11:0] SCORE_MAX = 12'h999;

  // Width of a per-frame pass count (0..N_TUBES).
  localparam int INC_W = $clog2(N_TUBES + 1);

  // 12 bits so an off-screen tube (x up to 2047) never wraps below BIRD_X.
  function automatic logic [11:0] tube_right(input logic [10:0] x);
    return {1'b0, x} + 12'(TUBE_WIDTH);
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: bundle between draw_game/input side and the game sequencer.
// Latency: n/a (wires only).
// Backpressure: n/a; all signals are levels or single-cycle pulses.
// master: drives vsync, mouse_left, collision, tube_x; reads the game outputs.
// slave : game_ctrl side, the mirror image.
interface game_ctrl_if;
  import game_pkg::*;

  logic                     vsync;
  logic                     mouse_left;
  logic                     collision;
  logic [N_TUBES-1:0][10:0] tube_x;
  logic                     game_rst;
  logic                     mouse_left_game;
  logic                     freeze;
  game_state_t              state;
  logic [11:0]              score;
  logic [11:0]              best_score;

  modport master (
    output vsync, mouse_left, collision, tube_x,
    input  game_rst, mouse_left_game, freeze, state, score, best_score
  );

  modport slave (
    input  vsync, mouse_left, collision, tube_x,
    output game_rst, mouse_left_game, freeze, state, score, best_score
  );

endinterface

// File: rtl/game_ctrl_bcd_counter.sv
// bcd_counter: 3-digit BCD counter, adds 0..N_TUBES per cycle, saturates at SCORE_MAX.
// Latency: 1 cycle from clr/inc to cnt.
// Backpressure: none; clr has priority over inc.
// Ports: clk, rst (async active-high), clr (sync clear), inc (amount), cnt (BCD value).
module bcd_counter
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [11:0]      cnt
);

  bcd_digit_t [2:0] cnt_q, cnt_d;
  logic [4:0]       sum0, sum1, sum2;
  logic             c0, c1, c2;
  logic [11:0]      sum_bcd;

  always_comb begin
    // inc <= 9, so each digit carries at most one into the next.
    sum0 = {1'b0, cnt_q[0]} + 5'(inc);
    c0   = (sum0 > 5'd9);
    if (c0) sum0 = sum0 - 5'd10;
    sum1 = {1'b0, cnt_q[1]} + {4'b0, c0};
    c1   = (sum1 > 5'd9);
    if (c1) sum1 = sum1 - 5'd10;
    sum2 = {1'b0, cnt_q[2]} + {4'b0, c1};
    c2   = (sum2 > 5'd9);
    sum_bcd = {sum2[3:0], sum1[3:0], sum0[3:0]};

    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (c2 || (sum_bcd > SCORE_MAX)) begin
      // Plain magnitude compare is valid on well-formed BCD.
      cnt_d = SCORE_MAX;
    end else begin
      cnt_d = sum_bcd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: IDLE/PLAY/DYING/OVER sequencer, restart pulse, jump gating, score and best score.
// Latency: state, game_rst and mouse_left_game change 1 cycle after the click edge; score 1 cycle after frame_tick.
// Backpressure: none; inputs are sampled every cycle, outputs are levels or 1-cycle pulses.
// Ports: clk, rst (async active-high); io (game_ctrl_if.slave): vsync, mouse_left, collision, tube_x in;
//   game_rst, mouse_left_game, freeze, state, score, best_score out.
// Build option: GAME_CTRL_HISCORE_EN keeps the best-score register; otherwise best_score is tied to 0.
module game_ctrl
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  game_ctrl_if.slave io
);

  localparam int DEATH_W = $clog2(DEATH_FRAMES);

  game_state_t              state_q, state_d;
  logic                     vsync_q, vsync_d;
  logic                     mouse_q, mouse_d;
  logic                     frame_tick_q, frame_tick_d;
  logic                     game_rst_q, game_rst_d;
  logic                     jump_q, jump_d;
  logic [DEATH_W-1:0]       death_cnt_q, death_cnt_d;
  logic [N_TUBES-1:0][11:0] prev_right_q, prev_right_d;
  logic [N_TUBES-1:0][11:0] right_pos;
  logic                     click;
  logic                     hit;
  logic                     score_clr;
  logic [INC_W-1:0]         pass_cnt;
  logic [INC_W-1:0]         score_inc;
  logic [11:0]              score;

  always_comb begin
    vsync_d      = io.vsync;
    mouse_d      = io.mouse_left;
    frame_tick_d = io.vsync & ~vsync_q;
    click        = io.mouse_left & ~mouse_q;
    // draw_game is still resetting during the game_rst cycle, so its collision is stale.
    hit          = (state_q == PLAY) && io.collision && !game_rst_q;

    right_pos = '0;
    pass_cnt  = '0;
    for (int i = 0; i < N_TUBES; i++) begin
      right_pos[i] = tube_right(io.tube_x[i]);
      // An off-screen tube (x >= SCREEN_W) is a wrap in progress and never scores.
      if ((prev_right_q[i] >= 12'(BIRD_X)) && (right_pos[i] < 12'(BIRD_X)) &&
          ({1'b0, io.tube_x[i]} < 12'(SCREEN_W))) begin
        pass_cnt = pass_cnt + INC_W'(1);
      end
    end

    // Reloading in the game_rst cycle stops the first frame from comparing against the last game.
    prev_right_d = (frame_tick_q || game_rst_q) ? right_pos : prev_right_q;

    state_d     = state_q;
    game_rst_d  = 1'b0;
    jump_d      = 1'b0;
    death_cnt_d = death_cnt_q;
    score_clr   = 1'b0;
    score_inc   = '0;

    case (state_q)
      IDLE, OVER: begin
        // The starting click only restarts; it is not forwarded as a jump.
        if (click) begin
          state_d    = PLAY;
          game_rst_d = 1'b1;
          score_clr  = 1'b1;
        end
      end
      PLAY: begin
        jump_d = click;
        if (hit) begin
          // Collision wins over a scoring tick in the same cycle.
          state_d     = DYING;
          death_cnt_d = '0;
        end else if (frame_tick_q && !game_rst_q) begin
          score_inc = pass_cnt;
        end
      end
      DYING: begin
        if (frame_tick_q) begin
          if (death_cnt_q == DEATH_W'(DEATH_FRAMES - 1)) begin
            state_d     = OVER;
            death_cnt_d = '0;
          end else begin
            death_cnt_d = death_cnt_q + DEATH_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b0;
      mouse_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      game_rst_q   <= 1'b0;
      jump_q       <= 1'b0;
      death_cnt_q  <= '0;
      prev_right_q <= '0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      mouse_q      <= mouse_d;
      frame_tick_q <= frame_tick_d;
      game_rst_q   <= game_rst_d;
      jump_q       <= jump_d;
      death_cnt_q  <= death_cnt_d;
      prev_right_q <= prev_right_d;
    end
  end

  bcd_counter u_score (
    .clk (clk),
    .rst (rst),
    .clr (score_clr),
    .inc (score_inc),
    .cnt (score)
  );

`ifdef GAME_CTRL_HISCORE_EN
  logic [11:0] best_q, best_d;

  // Sampled on the PLAY->DYING edge; score is not incremented in that cycle.
  always_comb begin
    best_d = best_q;
    if (hit && (score > best_q)) begin
      best_d = score;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q <= '0;
    end else begin
      best_q <= best_d;
    end
  end

  assign io.best_score = best_q;
`else
  assign io.best_score = '0;
`endif

  assign io.state           = state_q;
  assign io.freeze          = (state_q != PLAY);
  assign io.game_rst        = game_rst_q;
  assign io.mouse_left_game = jump_q;
  assign io.score           = score;

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_ctrl_if ifc ();

  game_ctrl dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
  );

`ifdef GAME_CTRL_HISCORE_EN
  localparam bit HISCORE = 1'b1;
`else
  localparam bit HISCORE = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_DYING = 2;
  localparam int M_OVER  = 3;

  int tests = 0;
  int fails = 0;

  // Game-level reference model: decimal score, frames spent dying, last right edges.
  int m_state, m_score, m_best, m_death;
  int m_prev [3];
  int tx [3];
  int vals [9] = '{100, 75, 85, 3, 1100, 1500, 79, 80, 81};

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_tubes();
    for (int i = 0; i < 3; i++) ifc.tube_x[i] = 11'(tx[i]);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/state"},  12'(ifc.state), 12'(m_state));
    chk({tag, "/score"},  ifc.score, to_bcd(m_score));
    chk({tag, "/best"},   ifc.best_score, HISCORE ? to_bcd(m_best) : 12'h000);
    chk({tag, "/freeze"}, 12'(ifc.freeze), 12'(m_state != M_PLAY));
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_score = 0;
    m_best  = 0;
    m_death = 0;
    for (int i = 0; i < 3; i++) m_prev[i] = 0;
  endtask

  task automatic model_collide();
    if (m_state == M_PLAY) begin
      if (m_score > m_best) m_best = m_score;
      m_state = M_DYING;
      m_death = 0;
    end
  endtask

  task automatic model_tick(input bit coll);
    int cnt;
    int r;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      r = tx[i] + TUBE_WIDTH;
      if (m_prev[i] >= BIRD_X && r < BIRD_X && tx[i] < SCREEN_W) cnt++;
    end
    if (m_state == M_PLAY && coll) begin
      model_collide();
    end else if (m_state == M_PLAY) begin
      m_score = (m_score + cnt > 999) ? 999 : m_score + cnt;
    end else if (m_state == M_DYING) begin
      m_death++;
      if (m_death == DEATH_FRAMES) m_state = M_OVER;
    end
    for (int i = 0; i < 3; i++) m_prev[i] = tx[i] + TUBE_WIDTH;
  endtask

  // mode 0: plain frame; 1: collision in the tick cycle; 2: click edge in the tick cycle.
  task automatic frame(input int mode);
    drive_tubes();
    step();
    ifc.vsync = 1'b1;
    step();
    if (mode == 1) ifc.collision = 1'b1;
    if (mode == 2) ifc.mouse_left = 1'b1;
    step();
    ifc.vsync     = 1'b0;
    ifc.collision = 1'b0;
    model_tick(mode == 1);
    check_all("frame");
    step();
    ifc.mouse_left = 1'b0;
    step();
  endtask

  task automatic press();
    bit enter;
    bit jump;
    enter = (m_state == M_IDLE || m_state == M_OVER);
    jump  = (m_state == M_PLAY);
    step();
    ifc.mouse_left = 1'b1;
    if (enter) begin
      m_state = M_PLAY;
      m_score = 0;
      for (int i = 0; i < 3; i++) m_prev[i] = tx[i] + TUBE_WIDTH;
    end
    step();
    chk("press/game_rst", 12'(ifc.game_rst), 12'(enter));
    chk("press/jump", 12'(ifc.mouse_left_game), 12'(jump));
    check_all("press");
    step();
    chk("press/game_rst_end", 12'(ifc.game_rst), 12'h000);
    chk("press/jump_end", 12'(ifc.mouse_left_game), 12'h000);
    step();
    step();
    ifc.mouse_left = 1'b0;
    step();
    step();
    chk("press/hold_no_repeat", 12'(ifc.mouse_left_game), 12'h000);
  endtask

  task automatic collide_pulse();
    step();
    ifc.collision = 1'b1;
    step();
    ifc.collision = 1'b0;
    model_collide();
    check_all("collide");
  endtask

  task automatic single_pass();
    tx[0] = 100;
    frame(0);
    tx[0] = 75;
    frame(0);
  endtask

  task automatic triple_pass();
    for (int i = 0; i < 3; i++) tx[i] = 100;
    frame(0);
    for (int i = 0; i < 3; i++) tx[i] = 75;
    frame(0);
  endtask

  initial begin
    ifc.vsync      = 1'b0;
    ifc.mouse_left = 1'b0;
    ifc.collision  = 1'b0;
    for (int i = 0; i < 3; i++) tx[i] = 1100;
    drive_tubes();
    model_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_all("reset");
    chk("reset/game_rst", 12'(ifc.game_rst), 12'h000);
    chk("reset/jump", 12'(ifc.mouse_left_game), 12'h000);

    // Game 1: start, jump, single passes, wrap, collision at 7.
    press();
    press();
    tx[0] = 100;
    frame(0);
    tx[0] = 75;
    frame(0);
    chk("first_pass", ifc.score, 12'h001);
    tx[0] = 3;
    frame(0);
    tx[0] = 1100;
    frame(0);
    chk("wrap_no_score", ifc.score, 12'h001);
    repeat (6) single_pass();
    collide_pulse();
    chk("best_after_7", ifc.best_score, HISCORE ? 12'h007 : 12'h000);
    collide_pulse();
    repeat (89) frame(0);
    chk("still_dying_89", 12'(ifc.state), 12'h002);
    press();
    frame(2);
    chk("over_after_90", 12'(ifc.state), 12'h003);
    collide_pulse();

    // Game 2: ends at 3 with a collision that coincides with a scoring tick.
    press();
    chk("restart_best_kept", ifc.best_score, HISCORE ? 12'h007 : 12'h000);
    repeat (3) single_pass();
    tx[0] = 100;
    frame(0);
    tx[0] = 75;
    frame(1);
    chk("collide_wins_score", ifc.score, 12'h003);
    chk("best_kept_7", ifc.best_score, HISCORE ? 12'h007 : 12'h000);
    repeat (90) frame(0);
    press();

    // Game 3: carry into hundreds, random tubes, saturation, async reset.
    repeat (100) single_pass();
    chk("score_100", ifc.score, 12'h100);
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 3; i++) tx[i] = vals[$urandom_range(0, 8)];
      frame(0);
    end
    while (m_score < 999) triple_pass();
    chk("score_999", ifc.score, 12'h999);
    triple_pass();
    chk("score_sat", ifc.score, 12'h999);

    step();
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst/game_rst", 12'(ifc.game_rst), 12'h000);
    chk("async_rst/jump", 12'(ifc.mouse_left_game), 12'h000);
    step();
    rst = 1'b0;
    step();
    check_all("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
